// File: rtl/hazard_unit_fwd.sv
// Decode-side hazard unit: tracks in-flight destinations, picks forwarding sources,
// stalls only on un-forwardable RAW hazards and holds a flush window after taken jumps.
module hazard_unit_fwd #(
    parameter  int ADDR_W       = 5,
    parameter  int DEPTH        = 3,
    parameter  int FLUSH_CYCLES = 2,
    parameter  int FWD_EN       = 1,
    parameter  int LOAD_STAGE   = 2,
    localparam int SEL_W        = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              jump_taken,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    input  logic              rs1_used,
    input  logic              rs2_used,
    input  logic [ADDR_W-1:0] rd,
    input  logic              rd_wr,
    input  logic              rd_is_load,
    output logic              control_hazard,
    output logic              data_hazard,
    output logic [SEL_W-1:0]  fwd_rs1_sel,
    output logic [SEL_W-1:0]  fwd_rs2_sel
);

    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    // Stage 1 is the instruction that left decode most recently.
    logic [DEPTH:1]    r_valid;
    logic [DEPTH:1]    r_load;
    logic [ADDR_W-1:0] r_rd [1:DEPTH];
    logic [CNT_W-1:0]  r_cnt;

    logic             w_ctrl;
    logic             w_data;
    logic             w_hit1, w_hit2;
    logic             w_fw1, w_fw2;
    logic [SEL_W-1:0] w_k1, w_k2;

    assign w_ctrl = jump_taken | (r_cnt != '0);

    // Scan oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        w_hit1 = 1'b0;
        w_fw1  = 1'b0;
        w_k1   = '0;
        w_hit2 = 1'b0;
        w_fw2  = 1'b0;
        w_k2   = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (r_valid[k] && (r_rd[k] == rs1) && (rs1 != '0) && rs1_used) begin
                w_hit1 = 1'b1;
                w_k1   = SEL_W'(k);
                w_fw1  = (FWD_EN != 0) && (!r_load[k] || (k >= LOAD_STAGE));
            end
            if (r_valid[k] && (r_rd[k] == rs2) && (rs2 != '0) && rs2_used) begin
                w_hit2 = 1'b1;
                w_k2   = SEL_W'(k);
                w_fw2  = (FWD_EN != 0) && (!r_load[k] || (k >= LOAD_STAGE));
            end
        end
    end

    assign w_data = ((w_hit1 & ~w_fw1) | (w_hit2 & ~w_fw2)) & ~w_ctrl;

    assign control_hazard = w_ctrl;
    assign data_hazard    = w_data;
    assign fwd_rs1_sel    = (w_ctrl | w_data | ~w_fw1) ? '0 : w_k1;
    assign fwd_rs2_sel    = (w_ctrl | w_data | ~w_fw2) ? '0 : w_k2;

    // A stalled or squashed decode instruction enters the tracker as a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_load  <= '0;
            r_cnt   <= '0;
            for (int k = 1; k <= DEPTH; k++) begin
                r_rd[k] <= '0;
            end
        end else if (!stall) begin
            for (int k = DEPTH; k >= 2; k--) begin
                r_valid[k] <= r_valid[k-1];
                r_load[k]  <= r_load[k-1];
                r_rd[k]    <= r_rd[k-1];
            end
            r_valid[1] <= rd_wr & (rd != '0) & ~w_data & ~w_ctrl;
            r_load[1]  <= rd_is_load;
            r_rd[1]    <= rd;
            if (jump_taken) begin
                r_cnt <= CNT_W'(FLUSH_CYCLES - 1);
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_unit_fwd.sv
// Directed bench for hazard_unit_fwd: a forwarding instance (defaults) and a
// FWD_EN=0 instance, each cycle's expected outputs queued and checked at negedge.
module tb_hazard_unit_fwd;

    logic clk;
    logic rst;
    logic stall;

    logic       m_jt, m_u1, m_u2, m_wr, m_ld;
    logic [4:0] m_rs1, m_rs2, m_rd;
    logic       m_ctrl, m_data;
    logic [1:0] m_s1, m_s2;

    logic       n_jt, n_u1, n_u2, n_wr, n_ld;
    logic [4:0] n_rs1, n_rs2, n_rd;
    logic       n_ctrl, n_data;
    logic [1:0] n_s1, n_s2;

    logic [11:0] exp_q[$];
    int total;
    int bad;

    localparam logic [5:0] Z = 6'b0;

    hazard_unit_fwd dut (
        .clk(clk), .rst(rst), .stall(stall), .jump_taken(m_jt),
        .rs1(m_rs1), .rs2(m_rs2), .rs1_used(m_u1), .rs2_used(m_u2),
        .rd(m_rd), .rd_wr(m_wr), .rd_is_load(m_ld),
        .control_hazard(m_ctrl), .data_hazard(m_data),
        .fwd_rs1_sel(m_s1), .fwd_rs2_sel(m_s2)
    );

    hazard_unit_fwd #(.FWD_EN(0)) dut_nf (
        .clk(clk), .rst(rst), .stall(stall), .jump_taken(n_jt),
        .rs1(n_rs1), .rs2(n_rs2), .rs1_used(n_u1), .rs2_used(n_u2),
        .rd(n_rd), .rd_wr(n_wr), .rd_is_load(n_ld),
        .control_hazard(n_ctrl), .data_hazard(n_data),
        .fwd_rs1_sel(n_s1), .fwd_rs2_sel(n_s2)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [5:0] e(input logic c, input logic d, input logic [1:0] s1, input logic [1:0] s2);
        return {c, d, s1, s2};
    endfunction

    task automatic cmp(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d want %0d", name, $time, act, exp);
        end
    endtask

    // driver tasks
    task automatic idle_in();
        stall = 1'b0;
        m_jt = 0; m_rs1 = 0; m_u1 = 0; m_rs2 = 0; m_u2 = 0; m_rd = 0; m_wr = 0; m_ld = 0;
        n_jt = 0; n_rs1 = 0; n_u1 = 0; n_rs2 = 0; n_u2 = 0; n_rd = 0; n_wr = 0; n_ld = 0;
    endtask

    task automatic set_m(input logic jt, input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                         input logic u2, input logic [4:0] rd, input logic wr, input logic ld);
        m_jt = jt; m_rs1 = rs1; m_u1 = u1; m_rs2 = rs2; m_u2 = u2; m_rd = rd; m_wr = wr; m_ld = ld;
    endtask

    task automatic set_n(input logic [4:0] rs1, input logic u1, input logic [4:0] rd, input logic wr);
        n_rs1 = rs1; n_u1 = u1; n_rd = rd; n_wr = wr;
    endtask

    task automatic cyc(input logic [5:0] em, input logic [5:0] en);
        exp_q.push_back({em, en});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        idle_in();
        repeat (n) cyc(Z, Z);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [11:0] x;
        if (exp_q.size() != 0) begin
            x = exp_q.pop_front();
            cmp("m_control_hazard", int'(m_ctrl), int'(x[11]));
            cmp("m_data_hazard",    int'(m_data), int'(x[10]));
            cmp("m_fwd_rs1_sel",    int'(m_s1),   int'(x[9:8]));
            cmp("m_fwd_rs2_sel",    int'(m_s2),   int'(x[7:6]));
            cmp("n_control_hazard", int'(n_ctrl), int'(x[5]));
            cmp("n_data_hazard",    int'(n_data), int'(x[4]));
            cmp("n_fwd_rs1_sel",    int'(n_s1),   int'(x[3:2]));
            cmp("n_fwd_rs2_sel",    int'(n_s2),   int'(x[1:0]));
        end
    end

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        idle_in();
        @(posedge clk);
        #1;

        // reset state; jump passes straight through during reset
        cyc(Z, Z);
        m_jt = 1'b1;
        cyc(e(1, 0, 0, 0), Z);
        rst = 1'b0;
        idle_in();
        cyc(Z, Z);

        // ALU forward from stage 1 then stage 2
        set_m(0, 0, 0, 0, 0, 5, 1, 0); cyc(Z, Z);
        set_m(0, 5, 1, 0, 0, 0, 0, 0); cyc(e(0, 0, 1, 0), Z);
        cyc(e(0, 0, 2, 0), Z);
        idle(3);

        // load-use: stall once, then forward from stage 2
        set_m(0, 0, 0, 0, 0, 7, 1, 1); cyc(Z, Z);
        set_m(0, 0, 0, 7, 1, 0, 0, 0); cyc(e(0, 1, 0, 0), Z);
        cyc(e(0, 0, 0, 2), Z);
        idle(3);

        // youngest match (load) wins over an older forwardable ALU result
        set_m(0, 0, 0, 0, 0, 4, 1, 0); cyc(Z, Z);
        set_m(0, 0, 0, 0, 0, 4, 1, 1); cyc(Z, Z);
        set_m(0, 4, 1, 0, 0, 0, 0, 0); cyc(e(0, 1, 0, 0), Z);
        cyc(e(0, 0, 2, 0), Z);
        idle(3);

        // x0 never tracked or matched; unused source ignored
        set_m(0, 0, 0, 0, 0, 0, 1, 0); cyc(Z, Z);
        set_m(0, 0, 1, 0, 0, 6, 1, 0); cyc(Z, Z);
        set_m(0, 0, 0, 6, 0, 0, 0, 0); cyc(Z, Z);
        set_m(0, 0, 0, 6, 1, 0, 0, 0); cyc(e(0, 0, 0, 2), Z);
        idle(3);

        // forwarding disabled: three stall cycles then clear
        set_n(0, 0, 3, 1); cyc(Z, Z);
        set_n(3, 1, 0, 0);
        cyc(Z, e(0, 1, 0, 0));
        cyc(Z, e(0, 1, 0, 0));
        cyc(Z, e(0, 1, 0, 0));
        cyc(Z, Z);
        idle(2);

        // jump: two-cycle window masks hazards and squashes decode writes
        set_m(0, 0, 0, 0, 0, 9, 1, 0);  cyc(Z, Z);
        set_m(1, 9, 1, 0, 0, 10, 1, 0); cyc(e(1, 0, 0, 0), Z);
        set_m(0, 9, 1, 0, 0, 11, 1, 0); cyc(e(1, 0, 0, 0), Z);
        set_m(0, 9, 1, 10, 1, 0, 0, 0); cyc(e(0, 0, 3, 0), Z);
        idle(3);

        // stall in window's second cycle stretches it by one
        set_m(1, 0, 0, 0, 0, 0, 0, 0); cyc(e(1, 0, 0, 0), Z);
        set_m(0, 0, 0, 0, 0, 0, 0, 0); stall = 1'b1; cyc(e(1, 0, 0, 0), Z);
        stall = 1'b0; cyc(e(1, 0, 0, 0), Z);
        cyc(Z, Z);

        // jump held across a stall restarts only once the stall drops
        set_m(1, 0, 0, 0, 0, 0, 0, 0); stall = 1'b1; cyc(e(1, 0, 0, 0), Z);
        stall = 1'b0; cyc(e(1, 0, 0, 0), Z);
        m_jt = 1'b0; cyc(e(1, 0, 0, 0), Z);
        cyc(Z, Z);

        // stall freezes tracked entries
        set_m(0, 0, 0, 0, 0, 13, 1, 0); cyc(Z, Z);
        set_m(0, 13, 1, 0, 0, 0, 0, 0); stall = 1'b1; cyc(e(0, 0, 1, 0), Z);
        stall = 1'b0; cyc(e(0, 0, 1, 0), Z);
        cyc(e(0, 0, 2, 0), Z);
        idle(3);

        // reset mid-window with a pending load hazard clears everything
        set_m(0, 0, 0, 0, 0, 14, 1, 1); cyc(Z, Z);
        set_m(1, 0, 0, 14, 1, 0, 0, 0); cyc(e(1, 0, 0, 0), Z);
        set_m(0, 0, 0, 14, 1, 0, 0, 0); rst = 1'b1; cyc(Z, Z);
        rst = 1'b0; cyc(Z, Z);
        idle(2);

        // final report
        @(posedge clk);
        @(posedge clk);
        cmp("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
